// File: rtl/vector_issue_seq.sv
// vector_issue_seq
// Per-slice issue sequencer sitting directly upstream of the vector slice.
// It accepts one decoded vector operation at a time and then runs it to
// completion:
//   1. read the source operands through the single-port VRF,
//   2. capture them into the selected unit's input registers,
//   3. pulse unit_start and wait for unit_done,
//   4. write the result back to the VRF (or to the VCR for CMP).
//
// Optional feature: define VECTOR_ISSUE_TIMEOUT_EN to enable a WAIT
// watchdog. After TIMEOUT cycles without unit_done it sets err, skips the
// write-back and returns to IDLE. Without the macro, WAIT waits forever.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   op_valid/op_ready operation handshake; op_ready is high only in IDLE
//   op_unit           0=MADD 1=LS 2=PLS 3=PERMUTE 4=CMP, 5..7 illegal
//   op_nsrc           source operand count 0..2 (3 is treated as 2)
//   op_ra/rb/rt       source A, source B and target registers
//   op_wb             write the result to the VRF (ignored for CMP)
//   unit_start        one-cycle start pulse to the unit
//   unit_done         unit result valid, sampled only in WAIT
//   vrf_en/we/addr    VRF access strobes
//   vrf_src_unit      write-back source select, holds outside WB
//   *_reg_in_en       operand capture enables, [0]=A [1]=B
//   vcr_we            VCR write enable (CMP write-back)
//   busy              sequencer not in IDLE
//   err               sticky error flag (illegal unit or watchdog timeout)
module vector_issue_seq #(
  parameter int VRF_SIZE = 32,
  parameter int UNIT_W   = 3,
  parameter int TIMEOUT  = 255,
  localparam int AW      = $clog2(VRF_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [UNIT_W-1:0] op_unit,
  input  logic [1:0]        op_nsrc,
  input  logic [AW-1:0]     op_ra,
  input  logic [AW-1:0]     op_rb,
  input  logic [AW-1:0]     op_rt,
  input  logic              op_wb,
  output logic              unit_start,
  input  logic              unit_done,
  output logic              vrf_en,
  output logic              vrf_we,
  output logic [AW-1:0]     vrf_addr,
  output logic [UNIT_W-1:0] vrf_src_unit,
  output logic [1:0]        valu_reg_in_en,
  output logic              vls_reg_in_en,
  output logic              cmp_reg_in_en,
  output logic              pls_reg_in_en,
  output logic [1:0]        permute_reg_in_en,
  output logic              vcr_we,
  output logic              busy,
  output logic              err
);

  localparam logic [UNIT_W-1:0] UNIT_MADD    = UNIT_W'(0);
  localparam logic [UNIT_W-1:0] UNIT_LS      = UNIT_W'(1);
  localparam logic [UNIT_W-1:0] UNIT_PLS     = UNIT_W'(2);
  localparam logic [UNIT_W-1:0] UNIT_PERMUTE = UNIT_W'(3);
  localparam logic [UNIT_W-1:0] UNIT_CMP     = UNIT_W'(4);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("vector_issue_seq: TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_B  = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_WB    = 3'd5
  } state_t;

  state_t            state_r, state_next_s;
  logic [UNIT_W-1:0] unit_r, unit_next_s;
  logic [1:0]        nsrc_r, nsrc_next_s;
  logic [AW-1:0]     ra_r, ra_next_s, rb_r, rb_next_s, rt_r, rt_next_s;
  logic              wb_r, wb_next_s;
  logic              err_r, err_next_s;

  // Outputs are registered: each is decoded from the next state and next
  // operation fields, so the registered value lines up with the state it
  // belongs to.
  logic              op_ready_r, busy_r, unit_start_r, vrf_en_r, vrf_we_r, vcr_we_r;
  logic              vls_en_r, cmp_en_r, pls_en_r;
  logic [1:0]        valu_en_r, perm_en_r;
  logic [AW-1:0]     vrf_addr_r;
  logic [UNIT_W-1:0] vrf_src_r;

  logic              op_ready_s, busy_s, unit_start_s, vrf_en_s, vrf_we_s, vcr_we_s;
  logic              vls_en_s, cmp_en_s, pls_en_s, cap0_s, cap1_s;
  logic [1:0]        valu_en_s, perm_en_s;
  logic [AW-1:0]     vrf_addr_s;
  logic [UNIT_W-1:0] vrf_src_s;

`ifdef VECTOR_ISSUE_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] wait_cnt_r;

  // Watchdog counter: restarts from 0 on WAIT entry, counts WAIT cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else if (state_r != S_WAIT) begin
      wait_cnt_r <= '0;
    end else begin
      wait_cnt_r <= wait_cnt_r + CW'(1);
    end
  end
`endif

  // Next-state logic and operation latching.
  always_comb begin
    state_next_s = state_r;
    unit_next_s  = unit_r;
    nsrc_next_s  = nsrc_r;
    ra_next_s    = ra_r;
    rb_next_s    = rb_r;
    rt_next_s    = rt_r;
    wb_next_s    = wb_r;
    err_next_s   = err_r;
    case (state_r)
      S_IDLE: begin
        if (op_valid) begin
          unit_next_s = op_unit;
          nsrc_next_s = (op_nsrc == 2'd3) ? 2'd2 : op_nsrc;
          ra_next_s   = op_ra;
          rb_next_s   = op_rb;
          rt_next_s   = op_rt;
          wb_next_s   = op_wb;
          // Illegal units are swallowed in IDLE so no strobe ever fires.
          if (op_unit > UNIT_CMP) begin
            err_next_s   = 1'b1;
            state_next_s = S_IDLE;
          end else if (op_nsrc == 2'd0) begin
            state_next_s = S_START;
          end else begin
            state_next_s = S_RD_A;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_RD_A: begin
        if (nsrc_r == 2'd1) begin
          state_next_s = S_START;
        end else begin
          state_next_s = S_RD_B;
        end
      end
      S_RD_B:  state_next_s = S_START;
      S_START: state_next_s = S_WAIT;
      S_WAIT: begin
        if (unit_done) begin
          state_next_s = S_WB;
`ifdef VECTOR_ISSUE_TIMEOUT_EN
        end else if (wait_cnt_r == CW'(TIMEOUT - 1)) begin
          state_next_s = S_IDLE;
          err_next_s   = 1'b1;
`endif
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_WB:    state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Output decode for the state being entered.
  always_comb begin
    op_ready_s   = (state_next_s == S_IDLE);
    busy_s       = (state_next_s != S_IDLE);
    unit_start_s = 1'b0;
    vrf_en_s     = 1'b0;
    vrf_we_s     = 1'b0;
    vrf_addr_s   = '0;
    vrf_src_s    = vrf_src_r;
    vcr_we_s     = 1'b0;
    cap0_s       = 1'b0;
    cap1_s       = 1'b0;
    case (state_next_s)
      S_RD_A: begin
        vrf_en_s   = 1'b1;
        vrf_addr_s = ra_next_s;
      end
      S_RD_B: begin
        vrf_en_s   = 1'b1;
        vrf_addr_s = rb_next_s;
        cap0_s     = 1'b1;  // data for A returns now
      end
      S_START: begin
        unit_start_s = 1'b1;
        if (nsrc_next_s == 2'd1) begin
          cap0_s = 1'b1;
        end else if (nsrc_next_s == 2'd2) begin
          cap1_s = 1'b1;
        end else begin
          cap0_s = 1'b0;
        end
      end
      S_WB: begin
        if (unit_next_s == UNIT_CMP) begin
          vcr_we_s = 1'b1;
        end else if (wb_next_s) begin
          vrf_en_s   = 1'b1;
          vrf_we_s   = 1'b1;
          vrf_addr_s = rt_next_s;
          vrf_src_s  = unit_next_s;
        end else begin
          vrf_en_s = 1'b0;
        end
      end
      default: begin
        vrf_en_s = 1'b0;
      end
    endcase
    // Single-input units only have a capture[0]; a B read is dropped.
    valu_en_s = (unit_next_s == UNIT_MADD)    ? {cap1_s, cap0_s} : 2'b00;
    perm_en_s = (unit_next_s == UNIT_PERMUTE) ? {cap1_s, cap0_s} : 2'b00;
    vls_en_s  = (unit_next_s == UNIT_LS)  && cap0_s;
    pls_en_s  = (unit_next_s == UNIT_PLS) && cap0_s;
    cmp_en_s  = (unit_next_s == UNIT_CMP) && cap0_s;
  end

  // State, latched operation and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= S_IDLE;
      unit_r       <= '0;
      nsrc_r       <= 2'd0;
      ra_r         <= '0;
      rb_r         <= '0;
      rt_r         <= '0;
      wb_r         <= 1'b0;
      err_r        <= 1'b0;
      op_ready_r   <= 1'b1;
      busy_r       <= 1'b0;
      unit_start_r <= 1'b0;
      vrf_en_r     <= 1'b0;
      vrf_we_r     <= 1'b0;
      vrf_addr_r   <= '0;
      vrf_src_r    <= '0;
      vcr_we_r     <= 1'b0;
      valu_en_r    <= 2'b00;
      perm_en_r    <= 2'b00;
      vls_en_r     <= 1'b0;
      pls_en_r     <= 1'b0;
      cmp_en_r     <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      unit_r       <= unit_next_s;
      nsrc_r       <= nsrc_next_s;
      ra_r         <= ra_next_s;
      rb_r         <= rb_next_s;
      rt_r         <= rt_next_s;
      wb_r         <= wb_next_s;
      err_r        <= err_next_s;
      op_ready_r   <= op_ready_s;
      busy_r       <= busy_s;
      unit_start_r <= unit_start_s;
      vrf_en_r     <= vrf_en_s;
      vrf_we_r     <= vrf_we_s;
      vrf_addr_r   <= vrf_addr_s;
      vrf_src_r    <= vrf_src_s;
      vcr_we_r     <= vcr_we_s;
      valu_en_r    <= valu_en_s;
      perm_en_r    <= perm_en_s;
      vls_en_r     <= vls_en_s;
      pls_en_r     <= pls_en_s;
      cmp_en_r     <= cmp_en_s;
    end
  end

  assign op_ready          = op_ready_r;
  assign busy              = busy_r;
  assign err               = err_r;
  assign unit_start        = unit_start_r;
  assign vrf_en            = vrf_en_r;
  assign vrf_we            = vrf_we_r;
  assign vrf_addr          = vrf_addr_r;
  assign vrf_src_unit      = vrf_src_r;
  assign vcr_we            = vcr_we_r;
  assign valu_reg_in_en    = valu_en_r;
  assign permute_reg_in_en = perm_en_r;
  assign vls_reg_in_en     = vls_en_r;
  assign pls_reg_in_en     = pls_en_r;
  assign cmp_reg_in_en     = cmp_en_r;

endmodule
